// File: rtl/issue_queue_multi_cdb_if.sv
// -----------------------------------------------------------------------------
// issue_queue_multi_cdb_if
//   Bundles the dispatch, writeback-broadcast, issue and flush signals of the
//   unified issue queue.
//   master : the surrounding pipeline (decode/rename, CDB, functional unit)
//   slave  : the issue queue itself
// Signals:
//   flush                      synchronous kill of all entries
//   disp_valid / disp_ready    dispatch handshake
//   disp_rs{1,2}_rdy/tag/val   operand state at dispatch
//   disp_dest_tag/payload      destination ROB tag and opaque op control
//   cdb_valid/tag/data         CDB_PORTS writeback broadcasts
//   iss_valid / iss_ready      issue handshake
//   iss_rs{1,2}_val, iss_dest_tag, iss_payload   selected op
//   count                      number of valid entries
// -----------------------------------------------------------------------------
interface issue_queue_multi_cdb_if #(
  parameter int DEPTH     = 8,
  parameter int CDB_PORTS = 2,
  parameter int TAG_W     = 5,
  parameter int DATA_W    = 32,
  parameter int PAYLOAD_W = 16
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                                flush;
  logic                                disp_valid;
  logic                                disp_ready;
  logic                                disp_rs1_rdy;
  logic                                disp_rs2_rdy;
  logic [TAG_W-1:0]                    disp_rs1_tag;
  logic [TAG_W-1:0]                    disp_rs2_tag;
  logic [DATA_W-1:0]                   disp_rs1_val;
  logic [DATA_W-1:0]                   disp_rs2_val;
  logic [TAG_W-1:0]                    disp_dest_tag;
  logic [PAYLOAD_W-1:0]                disp_payload;
  logic [CDB_PORTS-1:0]                cdb_valid;
  logic [CDB_PORTS-1:0][TAG_W-1:0]     cdb_tag;
  logic [CDB_PORTS-1:0][DATA_W-1:0]    cdb_data;
  logic                                iss_valid;
  logic                                iss_ready;
  logic [DATA_W-1:0]                   iss_rs1_val;
  logic [DATA_W-1:0]                   iss_rs2_val;
  logic [TAG_W-1:0]                    iss_dest_tag;
  logic [PAYLOAD_W-1:0]                iss_payload;
  logic [CNT_W-1:0]                    count;

  modport master (
    output flush, disp_valid, disp_rs1_rdy, disp_rs2_rdy, disp_rs1_tag,
           disp_rs2_tag, disp_rs1_val, disp_rs2_val, disp_dest_tag,
           disp_payload, cdb_valid, cdb_tag, cdb_data, iss_ready,
    input  disp_ready, iss_valid, iss_rs1_val, iss_rs2_val, iss_dest_tag,
           iss_payload, count
  );

  modport slave (
    input  flush, disp_valid, disp_rs1_rdy, disp_rs2_rdy, disp_rs1_tag,
           disp_rs2_tag, disp_rs1_val, disp_rs2_val, disp_dest_tag,
           disp_payload, cdb_valid, cdb_tag, cdb_data, iss_ready,
    output disp_ready, iss_valid, iss_rs1_val, iss_rs2_val, iss_dest_tag,
           iss_payload, count
  );
endinterface

// File: rtl/issue_queue_multi_cdb.sv
// -----------------------------------------------------------------------------
// issue_queue_multi_cdb
//   DEPTH-entry unified issue queue. Dispatched ops wait for their operands,
//   are woken by any of CDB_PORTS broadcast buses (also in the dispatch cycle)
//   and the oldest fully-ready entry is issued over a valid/ready handshake.
// Ports:
//   clk  clock
//   rst  asynchronous active-high reset
//   bus  issue_queue_multi_cdb_if.slave (dispatch, CDB, issue, flush, count)
// Age tracking: each valid entry holds a rank, 0 = oldest. Ranks always form
// a permutation of 0..count-1, so the minimum rank among eligible entries
// identifies the oldest ready op.
// -----------------------------------------------------------------------------
module issue_queue_multi_cdb #(
  parameter int DEPTH     = 8,
  parameter int CDB_PORTS = 2,
  parameter int TAG_W     = 5,
  parameter int DATA_W    = 32,
  parameter int PAYLOAD_W = 16
) (
  input logic                    clk,
  input logic                    rst,
  issue_queue_multi_cdb_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  typedef struct packed {
    logic              hit;
    logic [DATA_W-1:0] data;
  } cdb_hit_t;

  // Lowest-index matching port wins when several broadcast the same tag.
  function automatic cdb_hit_t cdb_match(
    input logic [TAG_W-1:0]                  tag,
    input logic [CDB_PORTS-1:0]              vld,
    input logic [CDB_PORTS-1:0][TAG_W-1:0]   tags,
    input logic [CDB_PORTS-1:0][DATA_W-1:0]  data
  );
    cdb_hit_t res;
    res = '0;
    for (int p = 0; p < CDB_PORTS; p++) begin
      if (!res.hit && vld[p] && (tags[p] == tag)) begin
        res.hit  = 1'b1;
        res.data = data[p];
      end
    end
    return res;
  endfunction

  // Entry state
  logic [DEPTH-1:0]     r_valid;
  logic [DEPTH-1:0]     r_r1;
  logic [DEPTH-1:0]     r_r2;
  logic [TAG_W-1:0]     r_tag1    [DEPTH];
  logic [TAG_W-1:0]     r_tag2    [DEPTH];
  logic [DATA_W-1:0]    r_val1    [DEPTH];
  logic [DATA_W-1:0]    r_val2    [DEPTH];
  logic [TAG_W-1:0]     r_dest    [DEPTH];
  logic [PAYLOAD_W-1:0] r_payload [DEPTH];
  logic [IDX_W-1:0]     r_age     [DEPTH];
  logic [CNT_W-1:0]     r_count;

  // Combinational control
  logic                 w_disp_ready;
  logic                 w_disp_fire;
  logic                 w_iss_valid;
  logic                 w_iss_fire;
  logic [IDX_W-1:0]     w_sel;
  logic [IDX_W-1:0]     w_sel_age;
  logic [IDX_W-1:0]     w_free;
  logic                 w_free_found;
  logic [IDX_W-1:0]     w_new_age;
  cdb_hit_t             w_wk1 [DEPTH];
  cdb_hit_t             w_wk2 [DEPTH];
  cdb_hit_t             w_dw1;
  cdb_hit_t             w_dw2;

  // Full is judged on registered count only, so an issue in a full cycle
  // frees the slot for dispatch one cycle later.
  assign w_disp_ready = (r_count != CNT_W'(DEPTH));
  assign w_disp_fire  = bus.disp_valid & w_disp_ready;
  assign w_iss_fire   = w_iss_valid & bus.iss_ready;
  // Rank of the newcomer: entries left after this cycle's issue removal.
  assign w_new_age    = r_count[IDX_W-1:0] - IDX_W'(w_iss_fire);

  // Lowest-index free slot.
  always_comb begin
    w_free       = '0;
    w_free_found = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!w_free_found && !r_valid[i]) begin
        w_free       = IDX_W'(i);
        w_free_found = 1'b1;
      end
    end
  end

  // Oldest eligible entry. Eligibility uses registered ready bits only, so
  // there is no CDB-to-issue combinational path.
  always_comb begin
    w_iss_valid = 1'b0;
    w_sel       = '0;
    w_sel_age   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_valid[i] && r_r1[i] && r_r2[i] &&
          (!w_iss_valid || (r_age[i] < w_sel_age))) begin
        w_iss_valid = 1'b1;
        w_sel       = IDX_W'(i);
        w_sel_age   = r_age[i];
      end
    end
  end

  // CDB tag matches for resident entries and for the dispatching op.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_wk1[i] = cdb_match(r_tag1[i], bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
      w_wk2[i] = cdb_match(r_tag2[i], bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
    end
    w_dw1 = cdb_match(bus.disp_rs1_tag, bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
    w_dw2 = cdb_match(bus.disp_rs2_tag, bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
  end

  // Control state: valid bits, ranks, count. Flush wins over everything else.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order inside the block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) r_age[i] <= '0;
    end else if (bus.flush) begin
      r_valid <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) r_age[i] <= '0;
    end else begin
      if (w_iss_fire) begin
        r_valid[w_sel] <= 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
          if (r_valid[i] && (r_age[i] > w_sel_age)) r_age[i] <= r_age[i] - 1'b1;
        end
      end
      // The free slot is invalid in registered state, so it never collides
      // with the issued slot or the rank decrement above.
      if (w_disp_fire) begin
        r_valid[w_free] <= 1'b1;
        r_age[w_free]   <= w_new_age;
      end
      r_count <= r_count + CNT_W'(w_disp_fire) - CNT_W'(w_iss_fire);
    end
  end

  // Operand/payload storage. Contents are only meaningful while the matching
  // valid bit is set, so a dispatch write during flush is harmless.
  // NOTE: the storage array is deliberately left without reset; valid bits
  // gate every use, and skipping reset keeps the array as plain flops/RAM.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (r_valid[i] && !r_r1[i] && w_wk1[i].hit) begin
        r_r1[i]   <= 1'b1;
        r_val1[i] <= w_wk1[i].data;
      end
      if (r_valid[i] && !r_r2[i] && w_wk2[i].hit) begin
        r_r2[i]   <= 1'b1;
        r_val2[i] <= w_wk2[i].data;
      end
    end
    if (w_disp_fire) begin
      r_tag1[w_free]    <= bus.disp_rs1_tag;
      r_tag2[w_free]    <= bus.disp_rs2_tag;
      r_dest[w_free]    <= bus.disp_dest_tag;
      r_payload[w_free] <= bus.disp_payload;
      if (bus.disp_rs1_rdy) begin
        r_r1[w_free]   <= 1'b1;
        r_val1[w_free] <= bus.disp_rs1_val;
      end else begin
        r_r1[w_free]   <= w_dw1.hit;
        r_val1[w_free] <= w_dw1.data;
      end
      if (bus.disp_rs2_rdy) begin
        r_r2[w_free]   <= 1'b1;
        r_val2[w_free] <= bus.disp_rs2_val;
      end else begin
        r_r2[w_free]   <= w_dw2.hit;
        r_val2[w_free] <= w_dw2.data;
      end
    end
  end

  assign bus.disp_ready   = w_disp_ready;
  assign bus.count        = r_count;
  assign bus.iss_valid    = w_iss_valid;
  assign bus.iss_rs1_val  = w_iss_valid ? r_val1[w_sel]    : 'x;
  assign bus.iss_rs2_val  = w_iss_valid ? r_val2[w_sel]    : 'x;
  assign bus.iss_dest_tag = w_iss_valid ? r_dest[w_sel]    : 'x;
  assign bus.iss_payload  = w_iss_valid ? r_payload[w_sel] : 'x;

endmodule
